// File: rtl/glu_audio_pkg.sv
// Shared types, widths and helpers for the GLU audio conditioner.
package glu_audio_pkg;

    typedef enum logic [1:0] {
        CLOSED = 2'd0,
        OPEN   = 2'd1,
        HOLD   = 2'd2
    } gate_state_t;

    localparam int SAMPLE_W = 16;
    localparam int GAIN_W   = 5;
    localparam logic [GAIN_W-1:0] GAIN_UNITY = 5'd16;

    // |x| with the single unrepresentable case (-32768) clamped to +32767.
    function automatic logic [SAMPLE_W-1:0] sat_abs(input logic signed [SAMPLE_W-1:0] x);
        if (x == {1'b1, {(SAMPLE_W-1){1'b0}}})
            return {1'b0, {(SAMPLE_W-1){1'b1}}};
        else if (x[SAMPLE_W-1])
            return SAMPLE_W'(-x);
        else
            return SAMPLE_W'(x);
    endfunction

endpackage

// File: rtl/glu_dc_blocker.sv
// Single-channel DC blocker, y = x - x_prev + y_prev - (y_prev >>> 8), saturated to 16 bits.
module glu_dc_blocker
    import glu_audio_pkg::*;
(
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       en_i,
    input  logic signed [SAMPLE_W-1:0] x_i,
    output logic signed [SAMPLE_W-1:0] y_o
);

    localparam int ACC_W = 18;
    localparam logic signed [ACC_W-1:0] MAX_V = 18'sd32767;
    localparam logic signed [ACC_W-1:0] MIN_V = -18'sd32768;

    function automatic logic signed [SAMPLE_W-1:0] sat16(input logic signed [ACC_W-1:0] v);
        if (v > MAX_V)
            return {1'b0, {(SAMPLE_W-1){1'b1}}};
        else if (v < MIN_V)
            return {1'b1, {(SAMPLE_W-1){1'b0}}};
        else
            return SAMPLE_W'(v);
    endfunction

    logic signed [SAMPLE_W-1:0] x_prev;
    logic signed [SAMPLE_W-1:0] y_prev;
    logic signed [ACC_W-1:0]    x_ext, xp_ext, yp_ext, acc;

    always_comb begin
        x_ext  = ACC_W'(x_i);
        xp_ext = ACC_W'(x_prev);
        yp_ext = ACC_W'(y_prev);
        acc    = x_ext - xp_ext + yp_ext - (yp_ext >>> 8);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            x_prev <= '0;
            y_prev <= '0;
            y_o    <= '0;
        end else if (en_i) begin
            x_prev <= x_i;
            y_prev <= sat16(acc);
            y_o    <= sat16(acc);
        end
    end

endmodule

// File: rtl/glu_audio_conditioner.sv
// GLU stereo post-processing: volume ramp, hysteretic noise gate with hold, registered output.
// Optional DC-blocking stage between capture and gate when GLU_AUDIO_DC_BLOCK_EN is defined.
module glu_audio_conditioner
    import glu_audio_pkg::*;
#(
    parameter int GATE_OPEN_THRESHOLD  = 64,
    parameter int GATE_CLOSE_THRESHOLD = 48,
    parameter int GATE_HOLD_SAMPLES    = 2048,
    parameter int RAMP_SAMPLES         = 64
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       sample_strobe_i,
    input  logic signed [SAMPLE_W-1:0] left_i,
    input  logic signed [SAMPLE_W-1:0] right_i,
    input  logic [3:0]                 volume_i,
    output logic signed [SAMPLE_W-1:0] audio_l_o,
    output logic signed [SAMPLE_W-1:0] audio_r_o,
    output logic                       valid_o,
    output logic                       gate_open_o
);

    localparam int DATA_W = SAMPLE_W;
    localparam int PROD_W = 21;
    localparam int HOLD_W = $clog2(GATE_HOLD_SAMPLES + 1);
    localparam int RAMP_W = $clog2(RAMP_SAMPLES + 1);
    localparam logic [DATA_W-1:0] OPEN_TH   = DATA_W'(GATE_OPEN_THRESHOLD);
    localparam logic [DATA_W-1:0] CLOSE_TH  = DATA_W'(GATE_CLOSE_THRESHOLD);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(GATE_HOLD_SAMPLES - 1);
    localparam logic [RAMP_W-1:0] RAMP_LAST = RAMP_W'(RAMP_SAMPLES - 1);

    // Gain 16 reproduces x exactly, so the 16-bit truncation never overflows.
    function automatic logic signed [DATA_W-1:0] scale(input logic signed [DATA_W-1:0] x,
                                                       input logic [GAIN_W-1:0] g);
        logic signed [PROD_W-1:0] prod;
        prod = $signed({{(PROD_W-DATA_W){x[DATA_W-1]}}, x}) *
               $signed({{(PROD_W-GAIN_W){1'b0}}, g});
        return DATA_W'(prod >>> 4);
    endfunction

    // Stage p0: capture
    logic                     vld_p0;
    logic signed [DATA_W-1:0] l_p0, r_p0;
    logic [3:0]               vol_p0;

    always_ff @(posedge clk_i) begin
        if (reset_i) vld_p0 <= 1'b0;
        else         vld_p0 <= sample_strobe_i;
    end

    always_ff @(posedge clk_i) begin
        if (sample_strobe_i) begin
            l_p0   <= left_i;
            r_p0   <= right_i;
            vol_p0 <= volume_i;
        end
    end

    logic                     g_vld;
    logic signed [DATA_W-1:0] g_l, g_r;
    logic [3:0]               g_vol;

`ifdef GLU_AUDIO_DC_BLOCK_EN
    // Stage dc: per-channel DC removal, volume travels alongside
    logic                     vld_dc;
    logic signed [DATA_W-1:0] l_dc, r_dc;
    logic [3:0]               vol_dc;

    glu_dc_blocker u_dc_l (.clk_i(clk_i), .reset_i(reset_i), .en_i(vld_p0), .x_i(l_p0), .y_o(l_dc));
    glu_dc_blocker u_dc_r (.clk_i(clk_i), .reset_i(reset_i), .en_i(vld_p0), .x_i(r_p0), .y_o(r_dc));

    always_ff @(posedge clk_i) begin
        if (reset_i) vld_dc <= 1'b0;
        else         vld_dc <= vld_p0;
    end

    always_ff @(posedge clk_i) begin
        if (vld_p0) vol_dc <= vol_p0;
    end

    assign g_vld = vld_dc;
    assign g_l   = l_dc;
    assign g_r   = r_dc;
    assign g_vol = vol_dc;
`else
    assign g_vld = vld_p0;
    assign g_l   = l_p0;
    assign g_r   = r_p0;
    assign g_vol = vol_p0;
`endif

    // Stage p1: gate decision and gain ramp
    gate_state_t       gate_state, gate_nxt;
    logic [HOLD_W-1:0] hold_cnt, hold_nxt, hold_inc;
    logic [GAIN_W-1:0] gain_cur, gain_nxt, target;
    logic [RAMP_W-1:0] ramp_cnt, ramp_nxt;
    logic [DATA_W-1:0] mag_l, mag_r, mag;

    always_comb begin
        mag_l    = sat_abs(g_l);
        mag_r    = sat_abs(g_r);
        mag      = (mag_l > mag_r) ? mag_l : mag_r;
        hold_inc = hold_cnt + HOLD_W'(1);
        gate_nxt = gate_state;
        hold_nxt = hold_cnt;
        case (gate_state)
            CLOSED: if (mag >= OPEN_TH) gate_nxt = OPEN;
            OPEN: begin
                if (mag < CLOSE_TH) begin
                    gate_nxt = HOLD;
                    hold_nxt = '0;
                end
            end
            HOLD: begin
                if (mag >= CLOSE_TH) begin
                    gate_nxt = OPEN;
                end else if (hold_inc >= HOLD_LAST) begin
                    gate_nxt = CLOSED;
                    hold_nxt = '0;
                end else begin
                    hold_nxt = hold_inc;
                end
            end
            default: gate_nxt = CLOSED;
        endcase
    end

    // A volume change simply moves the target; the ramp counter keeps its phase.
    always_comb begin
        target   = GAIN_W'(g_vol) + GAIN_W'(1);
        gain_nxt = gain_cur;
        ramp_nxt = ramp_cnt;
        if (gain_cur == target) begin
            ramp_nxt = '0;
        end else if (ramp_cnt == RAMP_LAST) begin
            ramp_nxt = '0;
            gain_nxt = (gain_cur < target) ? gain_cur + GAIN_W'(1) : gain_cur - GAIN_W'(1);
        end else begin
            ramp_nxt = ramp_cnt + RAMP_W'(1);
        end
    end

    logic                     vld_p1, mute_p1, open_p1;
    logic signed [DATA_W-1:0] l_p1, r_p1;
    logic [GAIN_W-1:0]        gain_p1;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            gate_state <= CLOSED;
            hold_cnt   <= '0;
            gain_cur   <= GAIN_UNITY;
            ramp_cnt   <= '0;
            vld_p1     <= 1'b0;
        end else begin
            vld_p1 <= g_vld;
            if (g_vld) begin
                gate_state <= gate_nxt;
                hold_cnt   <= hold_nxt;
                gain_cur   <= gain_nxt;
                ramp_cnt   <= ramp_nxt;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (g_vld) begin
            l_p1    <= g_l;
            r_p1    <= g_r;
            gain_p1 <= gain_cur;
            mute_p1 <= (gate_nxt == CLOSED);
            open_p1 <= (gate_nxt != CLOSED);
        end
    end

    // Stage p2: scale, mute and present
    logic                     vld_p2, open_p2;
    logic signed [DATA_W-1:0] l_p2, r_p2;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            vld_p2  <= 1'b0;
            open_p2 <= 1'b0;
            l_p2    <= '0;
            r_p2    <= '0;
        end else begin
            vld_p2 <= vld_p1;
            if (vld_p1) begin
                open_p2 <= open_p1;
                l_p2    <= mute_p1 ? '0 : scale(l_p1, gain_p1);
                r_p2    <= mute_p1 ? '0 : scale(r_p1, gain_p1);
            end
        end
    end

    assign audio_l_o   = l_p2;
    assign audio_r_o   = r_p2;
    assign valid_o     = vld_p2;
    assign gate_open_o = open_p2;

endmodule
